// File: rtl/median_window_feeder.sv
// median_window_feeder: buffers two previous lines of a raster pixel stream and,
// for every complete 3x3 neighbourhood, serializes its 9 pixels to the median
// core, then waits for the core's DSO strobe before sending the next window.
module median_window_feeder #(
  parameter int unsigned W     = 8,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [W-1:0] PIX_IN,
  input  logic         PIX_VAL,
  output logic         PIX_RDY,
  input  logic         MED_DSO,
  output logic [W-1:0] DI,
  output logic         DSI,
  output logic         FRAME_END
);

  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned IW   = 4;
  localparam int unsigned NWIN = 9;

  typedef enum logic [1:0] {
    ST_ACCEPT,
    ST_EMIT,
    ST_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row;
  logic [RW-1:0] row_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          last_win;
  logic          last_win_nxt;
  logic [W-1:0]  di_nxt;
  logic          dsi_nxt;
  logic          frame_end_nxt;

  // line buffers (L1 = previous line, L2 = line before) and the 3x3 window,
  // stored row-major with index 0 = oldest line, leftmost column
  logic [W-1:0]  lb1 [IMG_W];
  logic [W-1:0]  lb2 [IMG_W];
  logic [W-1:0]  win [NWIN];
  logic [W-1:0]  win_sh [NWIN];
  logic [W-1:0]  lb1_rd;
  logic [W-1:0]  lb2_rd;

  logic          accept;
  logic          at_last_col;
  logic          at_last_row;
  logic          win_ready;

  assign accept      = (state == ST_ACCEPT) && PIX_VAL;
  assign at_last_col = (col == CW'(IMG_W - 1));
  assign at_last_row = (row == RW'(IMG_H - 1));
  assign win_ready   = (row >= RW'(2)) && (col >= RW'(0) + RW'(0) + RW'(0) || 1'b1) && (col >= CW'(2));
  assign lb1_rd      = lb1[col];
  assign lb2_rd      = lb2[col];

  // ready is a pure function of the state so the upstream sees it immediately
  assign PIX_RDY = (state == ST_ACCEPT);

  // window after the pending accept: columns shift left, new right column
  // comes from the line buffers (read before they are updated) and the pixel
  always_comb begin
    win_sh[0] = win[1];
    win_sh[1] = win[2];
    win_sh[2] = lb2_rd;
    win_sh[3] = win[4];
    win_sh[4] = win[5];
    win_sh[5] = lb1_rd;
    win_sh[6] = win[7];
    win_sh[7] = win[8];
    win_sh[8] = PIX_IN;
  end

  // pixel datapath: line buffers and window registers are not reset
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb2[col] <= lb1_rd;
      lb1[col] <= PIX_IN;
      win      <= win_sh;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_ACCEPT;
      col       <= '0;
      row       <= '0;
      idx       <= '0;
      last_win  <= 1'b0;
      DI        <= '0;
      DSI       <= 1'b0;
      FRAME_END <= 1'b0;
    end else begin
      state     <= state_nxt;
      col       <= col_nxt;
      row       <= row_nxt;
      idx       <= idx_nxt;
      last_win  <= last_win_nxt;
      DI        <= di_nxt;
      DSI       <= dsi_nxt;
      FRAME_END <= frame_end_nxt;
    end
  end

  // next-state, counter advance and next output values
  always_comb begin
    state_nxt     = state;
    col_nxt       = col;
    row_nxt       = row;
    idx_nxt       = idx;
    last_win_nxt  = last_win;
    di_nxt        = '0;
    dsi_nxt       = 1'b0;
    frame_end_nxt = 1'b0;

    case (state)
      ST_ACCEPT: begin
        if (PIX_VAL) begin
          if (at_last_col) begin
            col_nxt = '0;
            row_nxt = at_last_row ? '0 : row + RW'(1);
          end else begin
            col_nxt = col + CW'(1);
          end
          if (win_ready) begin
            state_nxt    = ST_EMIT;
            idx_nxt      = '0;
            dsi_nxt      = 1'b1;
            di_nxt       = win_sh[0];
            last_win_nxt = at_last_row && at_last_col;
          end
        end
      end

      ST_EMIT: begin
        if (idx == IW'(NWIN - 1)) begin
          state_nxt = ST_WAIT;
        end else begin
          idx_nxt = idx + IW'(1);
          dsi_nxt = 1'b1;
          di_nxt  = win[idx + IW'(1)];
        end
      end

      ST_WAIT: begin
        if (MED_DSO) begin
          state_nxt     = ST_ACCEPT;
          frame_end_nxt = last_win;
        end
      end

      default: begin
        state_nxt = ST_ACCEPT;
      end
    endcase
  end

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: random frames with random valid gaps and
// stray/held DSO strobes, checked against windows computed from whole frames.
module tb_median_window_feeder;

  localparam int unsigned W     = 8;
  localparam int unsigned IMG_W = 5;
  localparam int unsigned IMG_H = 4;
  localparam int unsigned WPF   = (IMG_W - 2) * (IMG_H - 2);
  localparam int unsigned WB    = 9 * W;

  logic         CLK = 1'b0;
  logic         nRST;
  logic [W-1:0] PIX_IN;
  logic         PIX_VAL;
  logic         PIX_RDY;
  logic         MED_DSO;
  logic [W-1:0] DI;
  logic         DSI;
  logic         FRAME_END;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  bit stray_en = 1'b0;
  bit in_wait = 1'b0;
  bit pend = 1'b0;
  int nwin = 0;

  logic [W-1:0]  frm [IMG_H][IMG_W];
  logic [WB-1:0] exp_q[$];
  logic [WB-1:0] got_q[$];

  median_window_feeder #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_IN(PIX_IN), .PIX_VAL(PIX_VAL),
    .PIX_RDY(PIX_RDY), .MED_DSO(MED_DSO), .DI(DI), .DSI(DSI),
    .FRAME_END(FRAME_END)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 1 expected 0");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  // fill the frame with a ramp (mode 0) or random pixels
  task automatic gen_frame(input int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        frm[r][c] = (mode == 0) ? W'(r * IMG_W + c) : W'($urandom);
  endtask

  // every interior neighbourhood, raster order of its bottom-right pixel,
  // elements row-major from the oldest line
  task automatic model_frame();
    logic [WB-1:0] e;
    for (int r = 2; r < IMG_H; r++)
      for (int c = 2; c < IMG_W; c++) begin
        e = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e = (e << W) | WB'(frm[r - 2 + i][c - 2 + j]);
        exp_q.push_back(e);
      end
  endtask

  // offer one pixel until it is taken; PIX_VAL may drop randomly meanwhile
  task automatic send_px(input logic [W-1:0] p, input int gap_pct);
    bit done;
    bit v;
    bit rdy;
    int guard;
    done = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge CLK);
      v = ($urandom_range(0, 99) >= gap_pct);
      PIX_IN  = p;
      PIX_VAL = v;
      rdy = PIX_RDY;
      @(posedge CLK);
      if (v && rdy) done = 1'b1;
      guard++;
      if (!done && guard > 200) begin
        chk("px_accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input int gap_pct);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        send_px(frm[r][c], gap_pct);
  endtask

  task automatic release_bus();
    @(negedge CLK);
    PIX_VAL = 1'b0;
  endtask

  // median-core stand-in and output monitor
  initial begin : mon
    bit dsi_prev;
    bit pend_fe;
    int run;
    int plan;
    int cnt;
    int hold;
    logic [WB-1:0] cur;
    MED_DSO = 1'b0;
    dsi_prev = 1'b0;
    pend_fe = 1'b0;
    run = 0;
    plan = 0;
    cnt = 0;
    hold = 0;
    cur = '0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        dsi_prev = 1'b0;
        run = 0;
        cur = '0;
        hold = 0;
        pend = 1'b0;
        in_wait = 1'b0;
        nwin = 0;
        MED_DSO = 1'b0;
      end else begin
        if (FRAME_END) fe_cnt++;
        if (pend) begin
          chk("rdy_after_dso", PIX_RDY, 1);
          chk("frame_end", FRAME_END, pend_fe);
          pend = 1'b0;
        end
        if (DSI) begin
          cur = (cur << W) | WB'(DI);
          run++;
          chk("rdy_in_emit", PIX_RDY, 0);
        end else if (dsi_prev) begin
          chk("dsi_len", run, 9);
          got_q.push_back(cur);
          nwin++;
          run = 0;
          cur = '0;
          in_wait = 1'b1;
          cnt = 0;
          plan = $urandom_range(0, 6);
        end
        dsi_prev = DSI;
        if (in_wait) begin
          chk("rdy_in_wait", PIX_RDY, 0);
          if (cnt == plan) begin
            MED_DSO = 1'b1;
            hold = $urandom_range(0, 4);
            pend = 1'b1;
            pend_fe = ((nwin % WPF) == 0);
            in_wait = 1'b0;
          end else begin
            MED_DSO = 1'b0;
            cnt++;
          end
        end else if (hold > 0) begin
          MED_DSO = 1'b1;
          hold--;
        end else begin
          MED_DSO = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  initial begin : main
    int guard;
    int n;
    logic [WB-1:0] first_win;
    logic [WB-1:0] last_win;
    nRST = 1'b0;
    PIX_VAL = 1'b0;
    PIX_IN = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rdy", PIX_RDY, 1);
    chk("rst_dsi", DSI, 0);
    chk("rst_di", DI, 0);
    chk("rst_fe", FRAME_END, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("idle_rdy", PIX_RDY, 1);
    chk("idle_dsi", DSI, 0);

    // ramp frame, no gaps, no stray strobes
    gen_frame(0);
    model_frame();
    send_frame(0);

    // random frames back to back with gaps and stray strobes
    stray_en = 1'b1;
    gen_frame(1);
    model_frame();
    send_frame(30);
    gen_frame(1);
    model_frame();
    send_frame(0);

    // abort the first window of a partial frame with reset
    gen_frame(1);
    for (int k = 0; k < 2 * IMG_W + 3; k++)
      send_px(frm[k / IMG_W][k % IMG_W], 0);
    #3;
    chk("dsi_before_rst", DSI, 1);
    nRST = 1'b0;
    #1;
    chk("abort_dsi", DSI, 0);
    chk("abort_di", DI, 0);
    chk("abort_rdy", PIX_RDY, 1);
    chk("abort_fe", FRAME_END, 0);
    PIX_VAL = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    nRST = 1'b1;

    // fresh frame after reset must start at row 0, col 0
    gen_frame(1);
    model_frame();
    send_frame(50);
    release_bus();

    guard = 0;
    while ((got_q.size() < exp_q.size() || in_wait || pend) && guard < 400) begin
      @(posedge CLK);
      guard++;
    end
    if (guard >= 400) chk("drain_timeout", 0, 1);
    repeat (4) @(posedge CLK);

    chk("win_count", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("win", got_q[i], exp_q[i]);
    first_win = 72'h00_01_02_05_06_07_0a_0b_0c;
    last_win  = 72'h07_08_09_0c_0d_0e_11_12_13;
    if (got_q.size() >= WPF) begin
      chk("ramp_first_win", got_q[0], first_win);
      chk("ramp_last_win", got_q[WPF - 1], last_win);
    end else begin
      chk("ramp_win_present", got_q.size(), WPF);
    end
    chk("frame_end_count", fe_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/median_window_feeder.md
# median_window_feeder

Upstream stage of the median filter: accepts a raster-scan pixel stream, buffers two previous lines, and for every complete 3x3 neighbourhood emits its 9 pixels serially on DI/DSI, in the format the median core expects. It then holds off until the median core signals completion on its DSO output before sending the next window. Border pixels are not emitted, so a frame of IMG_W x IMG_H pixels produces (IMG_W-2) x (IMG_H-2) windows.

## Interface
- W, 8, pixel width in bits
- IMG_W, 16, pixels per line (>= 3)
- IMG_H, 16, lines per frame (>= 3)

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active-low
- PIX_IN  in  W  input pixel, raster order
- PIX_VAL  in  1  PIX_IN valid
- PIX_RDY  out  1  feeder can accept a pixel; transfer on PIX_VAL & PIX_RDY at a rising edge
- MED_DSO  in  1  median core result strobe (median DSO)
- DI  out  W  serialized window pixel to median core
- DSI  out  1  DI valid; high for exactly 9 consecutive cycles per window
- FRAME_END  out  1  one-cycle pulse after the last window of a frame completes

## Operation
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1.
  - Advance on each accepted pixel.
  - col wraps to 0 and increments row.
  - After pixel (IMG_H-1, IMG_W-1), both return to 0.
- Line buffers L1 and L2, each IMG_W x W, indexed by col. On accept of p at col c: L2[c] <= L1[c], L1[c] <= p. The buffers are not reset.
- Window registers: 3x3, w[row][col], row 0 = oldest line.
  - On accept, columns shift left.
  - The new right column is {L2[c], L1[c], p}, read before the line-buffer update.
- State machine:
  - ACCEPT
    - Entered at reset.
    - PIX_RDY=1.
    - On an accept with row>=2 and col>=2, go to EMIT with idx=0; otherwise stay.
  - EMIT
    - PIX_RDY=0, DSI=1, DI=w[idx/3][idx%3].
    - idx counts 0..8, in the order row r-2 (c-2, c-1, c), then row r-1, then row r.
    - After idx=8, go to WAIT.
  - WAIT
    - PIX_RDY=0, DSI=0.
    - On the first cycle with MED_DSO=1, go to ACCEPT.
    - If the completed window was the frame's last (row=IMG_H-1, col=IMG_W-1), assert FRAME_END for 1 cycle.
- MED_DSO is ignored outside WAIT. The median core holds DSO for several cycles; these are ignored once back in ACCEPT.
- PIX_VAL=0 in ACCEPT: hold, no state change.
- Reset mid-window: EMIT/WAIT are aborted and the block returns to ACCEPT with counters at 0. The partial frame is discarded.

## Timing
- Reset values:
  - State=ACCEPT, col=row=idx=0.
  - DI=0, DSI=0, FRAME_END=0, PIX_RDY=1 (combinational from state).
- DI, DSI and FRAME_END are registered.
- Window emission after a completing accept at edge k:
  - DSI=1 in cycles k+1..k+9.
  - DSI=0 from k+10 (WAIT).
- MED_DSO high in a WAIT cycle: ACCEPT and PIX_RDY=1 in the next cycle. FRAME_END=1 in that same next cycle when applicable.
- Throughput:
  - Non-window pixels: 1 pixel/cycle.
  - Window-completing pixels: stall for 9 cycles plus the median latency.

## Test plan
- **Reset:** drive nRST low mid-EMIT -> DSI=0, DI=0, PIX_RDY=1 immediately; after release, the next frame starts at row 0, col 0.
- **Single window:** IMG_W=IMG_H=3, pixels 1..9, MED_DSO pulse 5 cycles after DSI falls.
  - DI sequence 1,2,3,4,5,6,7,8,9 with DSI high exactly 9 cycles.
  - PIX_RDY=0 until the cycle after MED_DSO.
  - FRAME_END pulses once.
- **Window order / line buffers:** IMG_W=IMG_H=4, pixels 0..15.
  - 4 windows, emitted after pixels 10, 11, 14, 15.
  - First window: 0,1,2,4,5,6,8,9,10.
  - Last window: 5,6,7,9,10,11,13,14,15.
- **Backpressure / idle gaps:** random PIX_VAL gaps, and PIX_VAL held high during EMIT/WAIT -> no pixel lost or duplicated; windows identical to the gap-free run.
- **Stray MED_DSO:** MED_DSO high during ACCEPT and EMIT -> no state change. MED_DSO held high 5 cycles in WAIT -> exactly one return to ACCEPT.
- **Two frames back-to-back:** IMG_W=IMG_H=4 -> second frame windows use only second-frame pixels; FRAME_END pulses twice; counters wrap to 0.
